// File: rtl/ddr_cmd_decoder_if.sv
// Pin-side command/address bundle and registered decode results of ddr_cmd_decoder.
interface ddr_cmd_decoder_if #(
    parameter int BANKS = 16,
    parameter int ROWS  = 131072,
    parameter int COLS  = 1024
);
    localparam int BW = $clog2(BANKS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic          cke;
    logic          cs_n;
    logic          act_n;
    logic [16:0]   A;
    logic [1:0]    bg;
    logic [1:0]    ba;
    logic [18:0]   commands;
    logic [BW-1:0] bank;
    logic [RW-1:0] row;
    logic [CW-1:0] column;
    logic          halt;
    logic          err;

    modport master (
        output cke, cs_n, act_n, A, bg, ba,
        input  commands, bank, row, column, halt, err
    );

    modport slave (
        input  cke, cs_n, act_n, A, bg, ba,
        output commands, bank, row, column, halt, err
    );
endinterface

// File: rtl/ddr_cmd_decoder.sv
// DDR command decoder: one-hot command decode with per-bank open-row tracking,
// illegal-command suppression and a power-down / self-refresh FSM.
module ddr_cmd_decoder #(
    parameter int BANKS = 16,
    parameter int ROWS  = 131072,
    parameter int COLS  = 1024
) (
    input logic             clk,
    input logic             reset_n,
    ddr_cmd_decoder_if.slave bus
);
    localparam int BW = $clog2(BANKS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam int C_ACT  = 18;
    localparam int C_CFG  = 16;
    localparam int C_CKEH = 15;
    localparam int C_CKEL = 14;
    localparam int C_MRW  = 10;
    localparam int C_PD   = 9;
    localparam int C_PDX  = 8;
    localparam int C_PR   = 7;
    localparam int C_PRA  = 6;
    localparam int C_RD   = 5;
    localparam int C_RDA  = 4;
    localparam int C_REF  = 3;
    localparam int C_SRF  = 2;
    localparam int C_WR   = 1;
    localparam int C_WRA  = 0;

    typedef enum logic [1:0] {ACTIVE, PWRDN, SELFREF} pstate_e;

    pstate_e                  state_q, state_d;
    logic                     cke_prev_q;
    logic [BANKS-1:0]         open_q, open_d;
    logic [BANKS-1:0][RW-1:0] rows_q;
    logic [18:0]              cmd_q, cmd_d;
    logic [BW-1:0]            bank_q, bank_d;
    logic [RW-1:0]            row_q, row_d;
    logic [CW-1:0]            col_q, col_d;
    logic                     halt_q, halt_d;
    logic                     err_q, err_d;
    logic                     row_we;

    logic          d_nop, d_act, d_mrw, d_ref, d_pr, d_wr, d_rd, d_cfg;
    logic [BW-1:0] bidx;
    logic          auto_a10, cke_fall, any_open;

    assign bidx     = BW'({bus.bg, bus.ba});
    assign auto_a10 = bus.A[10];
    assign cke_fall = cke_prev_q & ~bus.cke;
    assign any_open = |open_q;

    // A16/A15/A14 act as ras_n/cas_n/we_n when act_n is high.
    always_comb begin
        d_nop = 1'b0; d_act = 1'b0; d_mrw = 1'b0; d_ref = 1'b0;
        d_pr  = 1'b0; d_wr  = 1'b0; d_rd  = 1'b0; d_cfg = 1'b0;
        if (bus.cs_n)        d_nop = 1'b1;
        else if (!bus.act_n) d_act = 1'b1;
        else begin
            case (bus.A[16:14])
                3'b000:  d_mrw = 1'b1;
                3'b001:  d_ref = 1'b1;
                3'b010:  d_pr  = 1'b1;
                3'b100:  d_wr  = 1'b1;
                3'b101:  d_rd  = 1'b1;
                3'b110:  d_cfg = 1'b1;
                default: d_nop = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = '0;
        bank_d  = '0;
        row_d   = '0;
        col_d   = '0;
        err_d   = 1'b0;
        open_d  = open_q;
        row_we  = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (d_nop) begin
                    if (cke_fall) begin
                        state_d      = PWRDN;
                        cmd_d[C_PD]   = 1'b1;
                        cmd_d[C_CKEL] = 1'b1;
                    end
                end else if (d_ref) begin
                    if (any_open) err_d = 1'b1;
                    else if (cke_fall) begin
                        state_d       = SELFREF;
                        cmd_d[C_SRF]  = 1'b1;
                        cmd_d[C_CKEL] = 1'b1;
                    end else cmd_d[C_REF] = 1'b1;
                end else if (cke_fall) begin
                    // Only NOP or REF may accompany a cke falling edge.
                    err_d = 1'b1;
                end else if (d_act) begin
                    if (open_q[bidx]) err_d = 1'b1;
                    else begin
                        cmd_d[C_ACT] = 1'b1;
                        bank_d       = bidx;
                        row_d        = RW'(bus.A);
                        open_d[bidx] = 1'b1;
                        row_we       = 1'b1;
                    end
                end else if (d_rd || d_wr) begin
                    if (!open_q[bidx]) err_d = 1'b1;
                    else begin
                        if (d_rd && auto_a10)       cmd_d[C_RDA] = 1'b1;
                        else if (d_rd)              cmd_d[C_RD]  = 1'b1;
                        else if (auto_a10)          cmd_d[C_WRA] = 1'b1;
                        else                        cmd_d[C_WR]  = 1'b1;
                        bank_d = bidx;
                        row_d  = rows_q[bidx];
                        col_d  = CW'(bus.A[9:0]);
                        if (auto_a10) open_d[bidx] = 1'b0;
                    end
                end else if (d_pr) begin
                    if (auto_a10) begin
                        cmd_d[C_PRA] = 1'b1;
                        open_d       = '0;
                    end else begin
                        cmd_d[C_PR]  = 1'b1;
                        bank_d       = bidx;
                        open_d[bidx] = 1'b0;
                    end
                end else if (d_mrw) begin
                    if (any_open) err_d = 1'b1;
                    else          cmd_d[C_MRW] = 1'b1;
                end else if (d_cfg) begin
                    cmd_d[C_CFG] = 1'b1;
                end
            end
            PWRDN: begin
                if (bus.cke) begin
                    state_d       = ACTIVE;
                    cmd_d[C_PDX]  = 1'b1;
                    cmd_d[C_CKEH] = 1'b1;
                end
            end
            SELFREF: begin
                if (bus.cke) begin
                    state_d       = ACTIVE;
                    cmd_d[C_CKEH] = 1'b1;
                end
            end
            default: state_d = ACTIVE;
        endcase
        halt_d = (state_d != ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ACTIVE;
            cke_prev_q <= 1'b1;
            open_q     <= '0;
            cmd_q      <= '0;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cke_prev_q <= bus.cke;
            open_q     <= open_d;
            cmd_q      <= cmd_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
        end
    end

    // Row storage needs no reset: it is only read behind a set open flag.
    always_ff @(posedge clk) begin
        if (reset_n && row_we) rows_q[bidx] <= RW'(bus.A);
    end

    assign bus.commands = cmd_q;
    assign bus.bank     = bank_q;
    assign bus.row      = row_q;
    assign bus.column   = col_q;
    assign bus.halt     = halt_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Directed scoreboard bench for ddr_cmd_decoder: stimulus queues expectations,
// a monitor compares one cycle after each issued edge.
module tb_ddr_cmd_decoder;
    localparam logic [18:0] M_NONE = 19'h00000;
    localparam logic [18:0] M_ACT  = 19'h40000;
    localparam logic [18:0] M_CFG  = 19'h10000;
    localparam logic [18:0] M_CKEH = 19'h08000;
    localparam logic [18:0] M_CKEL = 19'h04000;
    localparam logic [18:0] M_PD   = 19'h00200;
    localparam logic [18:0] M_PDX  = 19'h00100;
    localparam logic [18:0] M_PR   = 19'h00080;
    localparam logic [18:0] M_PRA  = 19'h00040;
    localparam logic [18:0] M_RD   = 19'h00020;
    localparam logic [18:0] M_REF  = 19'h00008;
    localparam logic [18:0] M_SRF  = 19'h00004;
    localparam logic [18:0] M_WR   = 19'h00002;
    localparam logic [18:0] M_WRA  = 19'h00001;

    typedef struct {
        logic [18:0] cmd;
        logic [3:0]  bank;
        logic [16:0] row;
        logic [9:0]  col;
        logic        halt;
        logic        err;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ddr_cmd_decoder_if #(.BANKS(16), .ROWS(131072), .COLS(1024)) bus ();

    ddr_cmd_decoder #(.BANKS(16), .ROWS(131072), .COLS(1024)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rn, input logic ck, input logic csn, input logic actn,
                        input logic [16:0] a, input logic [3:0] bgba,
                        input logic [18:0] ecmd, input logic [3:0] ebank, input logic [16:0] erow,
                        input logic [9:0] ecol, input logic ehalt, input logic eerr, input string nm);
        exp_t e;
        @(negedge clk);
        reset_n   = rn;
        bus.cke   = ck;
        bus.cs_n  = csn;
        bus.act_n = actn;
        bus.A     = a;
        bus.bg    = bgba[3:2];
        bus.ba    = bgba[1:0];
        @(posedge clk);
        e.cmd = ecmd; e.bank = ebank; e.row = erow; e.col = ecol;
        e.halt = ehalt; e.err = eerr; e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({bus.commands, bus.bank, bus.row, bus.column, bus.halt, bus.err} !==
                    {e.cmd, e.bank, e.row, e.col, e.halt, e.err}) begin
                    errors++;
                    $display("FAIL %s: got cmd=%h bank=%0d row=%h col=%h halt=%b err=%b, want cmd=%h bank=%0d row=%h col=%h halt=%b err=%b",
                             e.nm, bus.commands, bus.bank, bus.row, bus.column, bus.halt, bus.err,
                             e.cmd, e.bank, e.row, e.col, e.halt, e.err);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; bus.cke = 1'b1; bus.cs_n = 1'b1; bus.act_n = 1'b1;
        bus.A = '0; bus.bg = '0; bus.ba = '0;
        //   rn ck cs act A          bank   exp cmd          bank row       col    h  e
        step(0, 1, 1, 1, 17'h00000, 4'd0, M_NONE,         0, 17'h0,     10'h0,   0, 0, "rst0");
        step(0, 1, 1, 1, 17'h00000, 4'd0, M_NONE,         0, 17'h0,     10'h0,   0, 0, "rst1");
        step(1, 1, 0, 0, 17'h1ABCD, 4'd6, M_ACT,          6, 17'h1ABCD, 10'h0,   0, 0, "act6");
        step(1, 1, 0, 1, 17'h14055, 4'd6, M_RD,           6, 17'h1ABCD, 10'h055, 0, 0, "rd6");
        step(1, 1, 0, 1, 17'h14000, 4'd3, M_NONE,         0, 17'h0,     10'h0,   0, 1, "rd_closed3");
        step(1, 1, 0, 0, 17'h00001, 4'd6, M_NONE,         0, 17'h0,     10'h0,   0, 1, "act_open6");
        step(1, 1, 0, 1, 17'h103FF, 4'd6, M_WR,           6, 17'h1ABCD, 10'h3FF, 0, 0, "wr6");
        step(1, 1, 0, 1, 17'h10412, 4'd6, M_WRA,          6, 17'h1ABCD, 10'h012, 0, 0, "wra6");
        step(1, 1, 0, 1, 17'h14000, 4'd6, M_NONE,         0, 17'h0,     10'h0,   0, 1, "rd_after_wra");
        step(1, 1, 0, 0, 17'h00777, 4'd2, M_ACT,          2, 17'h00777, 10'h0,   0, 0, "act2");
        step(1, 1, 0, 1, 17'h04000, 4'd0, M_NONE,         0, 17'h0,     10'h0,   0, 1, "ref_open");
        step(1, 0, 0, 1, 17'h04000, 4'd0, M_NONE,         0, 17'h0,     10'h0,   0, 1, "ref_fall_open");
        step(1, 1, 0, 1, 17'h00000, 4'd0, M_NONE,         0, 17'h0,     10'h0,   0, 1, "mrw_open");
        step(1, 1, 0, 1, 17'h08000, 4'd5, M_PR,           5, 17'h0,     10'h0,   0, 0, "pr_closed5");
        step(1, 1, 0, 1, 17'h18000, 4'd0, M_CFG,          0, 17'h0,     10'h0,   0, 0, "cfg");
        step(1, 1, 1, 1, 17'h14000, 4'd6, M_NONE,         0, 17'h0,     10'h0,   0, 0, "nop_cs");
        step(1, 0, 1, 1, 17'h00000, 4'd0, M_PD | M_CKEL,  0, 17'h0,     10'h0,   1, 0, "pd_entry");
        step(1, 0, 0, 1, 17'h14000, 4'd2, M_NONE,         0, 17'h0,     10'h0,   1, 0, "pd_ignore");
        step(1, 1, 1, 1, 17'h00000, 4'd0, M_PDX | M_CKEH, 0, 17'h0,     10'h0,   0, 0, "pd_exit");
        step(1, 1, 0, 1, 17'h140AA, 4'd2, M_RD,           2, 17'h00777, 10'h0AA, 0, 0, "rd2_after_pd");
        step(1, 0, 0, 1, 17'h14000, 4'd2, M_NONE,         0, 17'h0,     10'h0,   0, 1, "rd_cke_fall");
        step(1, 1, 1, 1, 17'h00000, 4'd0, M_NONE,         0, 17'h0,     10'h0,   0, 0, "nop_cke_rise");
        step(1, 1, 0, 1, 17'h08400, 4'd0, M_PRA,          0, 17'h0,     10'h0,   0, 0, "pra");
        step(1, 1, 0, 1, 17'h04000, 4'd0, M_REF,          0, 17'h0,     10'h0,   0, 0, "ref");
        step(1, 0, 0, 1, 17'h04000, 4'd0, M_SRF | M_CKEL, 0, 17'h0,     10'h0,   1, 0, "sr_entry");
        step(1, 0, 0, 1, 17'h14000, 4'd2, M_NONE,         0, 17'h0,     10'h0,   1, 0, "sr_ignore_rd");
        step(1, 0, 0, 0, 17'h00123, 4'd4, M_NONE,         0, 17'h0,     10'h0,   1, 0, "sr_ignore_act");
        step(1, 1, 1, 1, 17'h00000, 4'd0, M_CKEH,         0, 17'h0,     10'h0,   0, 0, "sr_exit");
        step(1, 1, 0, 0, 17'h00010, 4'd1, M_ACT,          1, 17'h00010, 10'h0,   0, 0, "act1");
        step(1, 1, 0, 1, 17'h08000, 4'd1, M_PR,           1, 17'h0,     10'h0,   0, 0, "pr1");
        step(1, 0, 0, 1, 17'h04000, 4'd0, M_SRF | M_CKEL, 0, 17'h0,     10'h0,   1, 0, "sr_entry2");
        step(0, 0, 0, 0, 17'h00055, 4'd1, M_NONE,         0, 17'h0,     10'h0,   0, 0, "rst_in_sr");
        step(1, 1, 0, 1, 17'h14000, 4'd1, M_NONE,         0, 17'h0,     10'h0,   0, 1, "rd_after_rst");
        step(1, 1, 0, 0, 17'h00005, 4'd7, M_ACT,          7, 17'h00005, 10'h0,   0, 0, "act7");
        step(1, 0, 1, 1, 17'h00000, 4'd0, M_PD | M_CKEL,  0, 17'h0,     10'h0,   1, 0, "pd_entry2");
        step(0, 1, 1, 1, 17'h00000, 4'd0, M_NONE,         0, 17'h0,     10'h0,   0, 0, "rst_in_pd");
        step(1, 1, 0, 1, 17'h14000, 4'd7, M_NONE,         0, 17'h0,     10'h0,   0, 1, "rd7_after_rst");
        @(negedge clk);
        bus.cs_n = 1'b1; bus.cke = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
